cv32e40s_sha256_unit: RTL and testbench
=======================================

Name: cv32e40s_sha256_unit

Overview:
- Execution-side consumer of the SHA-256 operations produced by the decoder (sha256sum0/sum1/sig0/sig1, Zknh).
- Accepts one decoded op plus the rs1 operand from ID/EX and computes the sigma/sum function in a 2-stage pipeline.
- Returns the result and destination tag to writeback over a valid/ready handshake.
- Supports controller kill (flush) and, optionally, redundant-compute fault detection.

Parameters:
- TAG_W, 5, width of the destination register tag carried alongside each op.
- RESET_RESULT, 32'h0, reset value of result_o.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; synchronous, active-low
- valid_i  in  1  op presented
- ready_o  out  1  unit can accept op this cycle
- op_i  in  2  00=SUM0, 01=SUM1, 10=SIG0, 11=SIG1 (equals instr rs2[1:0])
- rs1_i  in  32  source operand
- tag_i  in  TAG_W  destination register address
- kill_i  in  1  flush all in-flight ops
- valid_o  out  1  result available
- ready_i  in  1  writeback accepts result
- result_o  out  32  computed value
- tag_o  out  TAG_W  tag of result_o
- busy_o  out  1  any stage holds a valid op
- alert_major_o  out  1  redundant-compute mismatch (feature only; tied 0 otherwise)

Behaviour:
- Functions (ror = rotate right, shr = logical shift right):
  - SUM0 = ror2 ^ ror13 ^ ror22
  - SUM1 = ror6 ^ ror11 ^ ror25
  - SIG0 = ror7 ^ ror18 ^ shr3
  - SIG1 = ror17 ^ ror19 ^ shr10
  - All 32-bit; no carries.
- Stage 1 (S1): on accept (valid_i && ready_o), register the three selected terms (3×32), tag, and s1_valid=1.
- Stage 2 (S2): on S1 advance, register the XOR of the terms into result_o, tag into tag_o, and s2_valid=1. valid_o = s2_valid.
- Latency: a result accepted in cycle N has valid_o=1 in cycle N+2 if there is no stall. Throughput is 1 op/cycle.
- Advance rules:
  - S2 frees when !s2_valid || ready_i.
  - S1 advances when s1_valid && S2 frees.
  - ready_o = !kill_i && (!s1_valid || S2 frees).
- Hold: while valid_o && !ready_i, result_o/tag_o stay stable and S1 holds its contents.
- Empty pipeline: valid_o=0, and result_o/tag_o keep their last values. These values are don't-care for the checker but must not X.
- kill_i: next cycle s1_valid=0 and s2_valid=0. No accept occurs in the kill cycle. A result on valid_o during the kill cycle may still complete a handshake if ready_i=1 in that same cycle.
- Simultaneous accept, S1 advance and S2 drain: all occur in one cycle with no bubble.
- Reset (rst_n=0 at a clock edge, any time including mid-operation):
  - Next cycle: s1_valid=0, s2_valid=0, valid_o=0, busy_o=0, ready_o=1 (when rst_n released), result_o=RESET_RESULT, tag_o=0, alert_major_o=0.
  - In-flight ops are discarded.
- busy_o = s1_valid || s2_valid.
- valid_i is only sampled when ready_o=1. The upstream stage must hold op_i/rs1_i/tag_i stable while valid_i && !ready_o.

Optional Feature:
- Macro: CV32E40S_SHA256_REDUNDANT_EN.
- Defined:
  - A second, independently coded combinational copy of the function is computed in stage 2 from S1 contents.
  - On any S1 advance where the copies differ, alert_major_o pulses high for exactly 1 cycle, aligned with valid_o.
  - The primary copy's result is still delivered.
  - alert_major_o resets to 0.
- Undefined: no duplicate logic; alert_major_o tied 0.

Test Plan:
- rs1=32'h00000001, op=SIG0, tag=5; ready_i=1 → 2 cycles later valid_o=1, result_o=32'h02004000, tag_o=5.
- Back-to-back ops on rs1=1: SUM0, SUM1, SIG1 in consecutive cycles → results 32'h40080400, 32'h04200080, 32'h0000A000 on 3 consecutive cycles; ready_o stays 1.
- Fill with 2 ops, ready_i=0 for 4 cycles → ready_o=0 once both stages are full; result_o held stable; releasing ready_i drains both in order with no loss or duplication.
- kill_i asserted with 2 ops in flight → next cycle valid_o=0, busy_o=0; the next op accepted after kill returns the correct result in 2 cycles.
- rst_n=0 mid-stream → next cycle valid_o=0, result_o=32'h0, tag_o=0, ready_o=1 after release.
- With CV32E40S_SHA256_REDUNDANT_EN, force the duplicate path to mismatch → alert_major_o=1 for 1 cycle, coincident with valid_o. Without the macro, alert_major_o stays 0 throughout.

Source files
------------

// File: rtl/cv32e40s_sha256_unit.sv
// Two-stage SHA-256 sigma/sum unit (Zknh) sitting between ID/EX and writeback.
// Optional redundant-compute checker enabled by defining CV32E40S_SHA256_REDUNDANT_EN.
module cv32e40s_sha256_unit #(
   parameter int          TAG_W        = 5,
   parameter logic [31:0] RESET_RESULT = 32'h0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [1:0]       op_i,
   input  logic [31:0]      rs1_i,
   input  logic [TAG_W-1:0] tag_i,
   input  logic             kill_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [31:0]      result_o,
   output logic [TAG_W-1:0] tag_o,
   output logic             busy_o,
   output logic             alert_major_o
);

   typedef enum logic [1:0] {
      OP_SUM0 = 2'b00,
      OP_SUM1 = 2'b01,
      OP_SIG0 = 2'b10,
      OP_SIG1 = 2'b11
   } sha_op_e;

   function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   logic [31:0]      term0_next, term1_next, term2_next;
   logic [31:0]      s1_term0_reg, s1_term1_reg, s1_term2_reg;
   logic [TAG_W-1:0] s1_tag_reg;
   logic             s1_valid_reg;
   logic             s2_valid_reg;
   logic [31:0]      result_reg;
   logic [TAG_W-1:0] tag_reg;
   logic [31:0]      result_next;
   logic             s2_free;
   logic             s1_adv;
   logic             accept;

   assign s2_free = !s2_valid_reg || ready_i;
   assign s1_adv  = s1_valid_reg && s2_free;
   assign ready_o = !kill_i && (!s1_valid_reg || s2_free);
   assign accept  = valid_i && ready_o;

   assign valid_o  = s2_valid_reg;
   assign result_o = result_reg;
   assign tag_o    = tag_reg;
   assign busy_o   = s1_valid_reg || s2_valid_reg;

   always_comb begin
      term0_next = '0;
      term1_next = '0;
      term2_next = '0;
      case (sha_op_e'(op_i))
         OP_SUM0: begin
            term0_next = ror32(rs1_i, 2);
            term1_next = ror32(rs1_i, 13);
            term2_next = ror32(rs1_i, 22);
         end
         OP_SUM1: begin
            term0_next = ror32(rs1_i, 6);
            term1_next = ror32(rs1_i, 11);
            term2_next = ror32(rs1_i, 25);
         end
         OP_SIG0: begin
            term0_next = ror32(rs1_i, 7);
            term1_next = ror32(rs1_i, 18);
            term2_next = rs1_i >> 3;
         end
         default: begin
            term0_next = ror32(rs1_i, 17);
            term1_next = ror32(rs1_i, 19);
            term2_next = rs1_i >> 10;
         end
      endcase
   end

   assign result_next = s1_term0_reg ^ s1_term1_reg ^ s1_term2_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s1_term0_reg <= '0;
         s1_term1_reg <= '0;
         s1_term2_reg <= '0;
         s1_tag_reg   <= '0;
      end else if (kill_i) begin
         s1_valid_reg <= 1'b0;
      end else if (accept) begin
         s1_valid_reg <= 1'b1;
         s1_term0_reg <= term0_next;
         s1_term1_reg <= term1_next;
         s1_term2_reg <= term2_next;
         s1_tag_reg   <= tag_i;
      end else if (s1_adv) begin
         s1_valid_reg <= 1'b0;
      end
   end

   // Output registers only load on a real advance, so they keep their last value when idle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_valid_reg <= 1'b0;
         result_reg   <= RESET_RESULT;
         tag_reg      <= '0;
      end else if (kill_i) begin
         s2_valid_reg <= 1'b0;
      end else if (s1_adv) begin
         s2_valid_reg <= 1'b1;
         result_reg   <= result_next;
         tag_reg      <= s1_tag_reg;
      end else if (ready_i) begin
         s2_valid_reg <= 1'b0;
      end
   end

`ifdef CV32E40S_SHA256_REDUNDANT_EN
   logic [31:0] s1_rs1_reg;
   logic [1:0]  s1_op_reg;
   logic [31:0] dup_result;
   logic        alert_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_rs1_reg <= '0;
         s1_op_reg  <= '0;
      end else if (!kill_i && accept) begin
         s1_rs1_reg <= rs1_i;
         s1_op_reg  <= op_i;
      end
   end

   // Independent formulation: rotations as explicit concatenations of the raw operand.
   always_comb begin
      dup_result = '0;
      unique case (s1_op_reg)
         2'b00: dup_result = {s1_rs1_reg[1:0],  s1_rs1_reg[31:2]}
                           ^ {s1_rs1_reg[12:0], s1_rs1_reg[31:13]}
                           ^ {s1_rs1_reg[21:0], s1_rs1_reg[31:22]};
         2'b01: dup_result = {s1_rs1_reg[5:0],  s1_rs1_reg[31:6]}
                           ^ {s1_rs1_reg[10:0], s1_rs1_reg[31:11]}
                           ^ {s1_rs1_reg[24:0], s1_rs1_reg[31:25]};
         2'b10: dup_result = {s1_rs1_reg[6:0],  s1_rs1_reg[31:7]}
                           ^ {s1_rs1_reg[17:0], s1_rs1_reg[31:18]}
                           ^ {3'b000, s1_rs1_reg[31:3]};
         default: dup_result = {s1_rs1_reg[16:0], s1_rs1_reg[31:17]}
                             ^ {s1_rs1_reg[18:0], s1_rs1_reg[31:19]}
                             ^ {10'b0, s1_rs1_reg[31:10]};
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alert_reg <= 1'b0;
      end else begin
         alert_reg <= !kill_i && s1_adv && (dup_result != result_next);
      end
   end

   assign alert_major_o = alert_reg;
`else
   assign alert_major_o = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e40s_sha256_unit.sv
// Directed bench for cv32e40s_sha256_unit: vector table plus stall, kill and reset sequences.
module tb_cv32e40s_sha256_unit;

   localparam int TAG_W = 5;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             valid_i;
   logic             ready_o;
   logic [1:0]       op_i;
   logic [31:0]      rs1_i;
   logic [TAG_W-1:0] tag_i;
   logic             kill_i;
   logic             valid_o;
   logic             ready_i;
   logic [31:0]      result_o;
   logic [TAG_W-1:0] tag_o;
   logic             busy_o;
   logic             alert_major_o;

   int checks = 0;
   int errors = 0;

   localparam logic [1:0] SUM0 = 2'b00, SUM1 = 2'b01, SIG0 = 2'b10, SIG1 = 2'b11;

   typedef struct {
      logic [1:0]       op;
      logic [31:0]      rs1;
      logic [TAG_W-1:0] tag;
      logic [31:0]      exp;
   } vec_t;

   vec_t vecs[9];

   cv32e40s_sha256_unit #(.TAG_W(TAG_W), .RESET_RESULT(32'h0)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .valid_i       (valid_i),
      .ready_o       (ready_o),
      .op_i          (op_i),
      .rs1_i         (rs1_i),
      .tag_i         (tag_i),
      .kill_i        (kill_i),
      .valid_o       (valid_o),
      .ready_i       (ready_i),
      .result_o      (result_o),
      .tag_o         (tag_o),
      .busy_o        (busy_o),
      .alert_major_o (alert_major_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] rs1,
                        input logic [TAG_W-1:0] tag);
      valid_i = v;
      op_i    = op;
      rs1_i   = rs1;
      tag_i   = tag;
   endtask

   // No fault is injected, so the redundancy alert must never fire.
   always @(negedge clk) begin
      if (rst_n === 1'b1) chk("alert_quiet", {31'b0, alert_major_o}, 32'h0);
   end

   initial begin
      vecs[0] = '{SIG0, 32'h00000001, 5'd5,  32'h02004000};
      vecs[1] = '{SUM0, 32'h00000001, 5'd1,  32'h40080400};
      vecs[2] = '{SUM1, 32'h00000001, 5'd2,  32'h04200080};
      vecs[3] = '{SIG1, 32'h00000001, 5'd3,  32'h0000A000};
      vecs[4] = '{SIG1, 32'h80000000, 5'd9,  32'h00205000};
      vecs[5] = '{SIG0, 32'h80000000, 5'd10, 32'h11002000};
      vecs[6] = '{SIG0, 32'hFFFFFFFF, 5'd31, 32'h1FFFFFFF};
      vecs[7] = '{SUM0, 32'hFFFFFFFF, 5'd17, 32'hFFFFFFFF};
      vecs[8] = '{SIG1, 32'hFFFFFFFF, 5'd0,  32'h003FFFFF};

      rst_n   = 1'b0;
      kill_i  = 1'b0;
      ready_i = 1'b1;
      drive(1'b0, 2'b00, 32'h0, '0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("rst_valid",  {31'b0, valid_o}, 32'h0);
      chk("rst_busy",   {31'b0, busy_o},  32'h0);
      chk("rst_ready",  {31'b0, ready_o}, 32'h1);
      chk("rst_result", result_o,         32'h0);
      chk("rst_tag",    {27'b0, tag_o},   32'h0);

      // Back-to-back table: one op per cycle, result two cycles later.
      for (int i = 0; i < 11; i++) begin
         next_cycle();
         if (i < 9) drive(1'b1, vecs[i].op, vecs[i].rs1, vecs[i].tag);
         else       drive(1'b0, 2'b00, 32'h0, '0);
         #1;
         chk("tbl_ready", {31'b0, ready_o}, 32'h1);
         if (i >= 2) begin
            chk("tbl_valid",  {31'b0, valid_o}, 32'h1);
            chk("tbl_result", result_o, vecs[i-2].exp);
            chk("tbl_tag",    {27'b0, tag_o}, {27'b0, vecs[i-2].tag});
         end else begin
            chk("tbl_lat_valid", {31'b0, valid_o}, 32'h0);
         end
      end
      next_cycle();
      #1;
      chk("tbl_drained_valid", {31'b0, valid_o}, 32'h0);
      chk("tbl_drained_busy",  {31'b0, busy_o},  32'h0);

      // Kill with two ops in flight; the op offered in the kill cycle must be dropped.
      next_cycle(); drive(1'b1, SIG0, 32'h1, 5'd5);
      next_cycle(); drive(1'b1, SUM0, 32'h1, 5'd6);
      next_cycle(); drive(1'b1, SUM1, 32'h1, 5'd7); kill_i = 1'b1;
      #1;
      chk("kill_ready",  {31'b0, ready_o}, 32'h0);
      chk("kill_busy",   {31'b0, busy_o},  32'h1);
      chk("kill_valid",  {31'b0, valid_o}, 32'h1);
      chk("kill_result", result_o, 32'h02004000);
      next_cycle(); kill_i = 1'b0; drive(1'b1, SIG1, 32'h80000000, 5'd9);
      #1;
      chk("postkill_valid", {31'b0, valid_o}, 32'h0);
      chk("postkill_busy",  {31'b0, busy_o},  32'h0);
      chk("postkill_ready", {31'b0, ready_o}, 32'h1);
      next_cycle(); drive(1'b0, 2'b00, 32'h0, '0);
      #1;
      chk("postkill_lat_valid", {31'b0, valid_o}, 32'h0);
      chk("postkill_lat_busy",  {31'b0, busy_o},  32'h1);
      next_cycle();
      #1;
      chk("postkill_res_valid", {31'b0, valid_o}, 32'h1);
      chk("postkill_result",    result_o, 32'h00205000);
      chk("postkill_tag",       {27'b0, tag_o}, 32'd9);
      next_cycle();
      #1;
      chk("postkill_drain", {31'b0, valid_o}, 32'h0);

      // Stall: two ops fill both stages while writeback refuses, then drain in order.
      next_cycle(); ready_i = 1'b0; drive(1'b1, SUM0, 32'h1, 5'd1);
      #1;
      chk("stall_ready0", {31'b0, ready_o}, 32'h1);
      next_cycle(); drive(1'b1, SUM1, 32'h1, 5'd2);
      #1;
      chk("stall_ready1", {31'b0, ready_o}, 32'h1);
      for (int c = 0; c < 4; c++) begin
         next_cycle(); drive(1'b0, 2'b00, 32'h0, '0);
         #1;
         chk("stall_ready_low", {31'b0, ready_o}, 32'h0);
         chk("stall_valid",     {31'b0, valid_o}, 32'h1);
         chk("stall_result",    result_o, 32'h40080400);
         chk("stall_tag",       {27'b0, tag_o}, 32'd1);
      end
      next_cycle(); ready_i = 1'b1;
      #1;
      chk("drain_a_ready",  {31'b0, ready_o}, 32'h1);
      chk("drain_a_result", result_o, 32'h40080400);
      chk("drain_a_tag",    {27'b0, tag_o}, 32'd1);
      next_cycle();
      #1;
      chk("drain_b_valid",  {31'b0, valid_o}, 32'h1);
      chk("drain_b_result", result_o, 32'h04200080);
      chk("drain_b_tag",    {27'b0, tag_o}, 32'd2);
      next_cycle();
      #1;
      chk("drain_done_valid", {31'b0, valid_o}, 32'h0);
      chk("drain_done_busy",  {31'b0, busy_o},  32'h0);

      // Reset in the middle of a stalled stream.
      next_cycle(); ready_i = 1'b0; drive(1'b1, SIG0, 32'h80000000, 5'd3);
      next_cycle(); drive(1'b1, SUM1, 32'h1, 5'd4);
      next_cycle(); drive(1'b0, 2'b00, 32'h0, '0); rst_n = 1'b0;
      #1;
      chk("prerst_busy", {31'b0, busy_o}, 32'h1);
      next_cycle(); rst_n = 1'b1;
      #1;
      chk("midrst_valid",  {31'b0, valid_o}, 32'h0);
      chk("midrst_busy",   {31'b0, busy_o},  32'h0);
      chk("midrst_ready",  {31'b0, ready_o}, 32'h1);
      chk("midrst_result", result_o, 32'h0);
      chk("midrst_tag",    {27'b0, tag_o}, 32'h0);
      next_cycle();
      #1;
      chk("midrst_stays_empty", {31'b0, valid_o}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
